shot_controller: RTL and testbench

// - Upstream of every enemy slot: turns the raw KEY buttons and the SW weapon select into the
//   hit_angle bus and the 1-cycle outgoing_projectiles pulse that all enemy instances sample.
// - Debounces the buttons, rotates the turret over 16 angles, enforces a per-weapon cooldown
//   and rations sniper (type 11) shots.

---
 rtl/shot_controller.sv | 205 ++++++++++++++++++++
 tb/tb_shot_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_controller.sv
// Purpose : turns raw KEY buttons plus the SW weapon select into the turret angle
//           and a 1-cycle fire pulse shared by every enemy slot.
// Latency : fire event seen in IDLE at cycle N -> pulse during N+1 -> ready at N+2+cooldown.
//           A raw key edge becomes an event 2 (sync) + DEBOUNCE_CYCLES cycles later.
// Backpr. : none; fire events outside IDLE are dropped, never queued.
// Ports   : clk, reset_n (async, active-low); key_left/key_right/key_fire (raw, active-low);
//           shootingtype[1:0] (00 none, 01 spread, 10 double, 11 sniper);
//           hit_angle[3:0], outgoing_projectiles, ready, sniper_left[1:0], shots_fired[15:0].
// Config  : define AUTOFIRE_EN to keep firing while key_fire stays pressed after cooldown.
module shot_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned COOLDOWN_SPREAD = 12500000,
  parameter int unsigned COOLDOWN_DOUBLE = 25000000,
  parameter int unsigned COOLDOWN_SNIPER = 50000000,
  parameter int unsigned SNIPER_CHARGES  = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        key_fire,
  input  logic [1:0]  shootingtype,
  output logic [3:0]  hit_angle,
  output logic        outgoing_projectiles,
  output logic        ready,
  output logic [1:0]  sniper_left,
  output logic [15:0] shots_fired
);

  localparam int unsigned CD_MAX =
    (COOLDOWN_SPREAD > COOLDOWN_DOUBLE) ?
      ((COOLDOWN_SPREAD > COOLDOWN_SNIPER) ? COOLDOWN_SPREAD : COOLDOWN_SNIPER) :
      ((COOLDOWN_DOUBLE > COOLDOWN_SNIPER) ? COOLDOWN_DOUBLE : COOLDOWN_SNIPER);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CD_W = $clog2(CD_MAX + 1);

  // Key indices inside the 3-bit key vectors.
  localparam int K_LEFT  = 0;
  localparam int K_RIGHT = 1;
  localparam int K_FIRE  = 2;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FIRE     = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  // Input conditioning state (raw keys are active-low, pressed_* is active-high).
  logic [2:0]           sync1_q, sync1_d;
  logic [2:0]           sync2_q, sync2_d;
  logic [2:0]           pressed_q, pressed_d;
  logic [2:0]           pressed_prev_q, pressed_prev_d;
  logic [2:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]           evt;

  // Control state.
  state_t               state_q, state_d;
  logic [1:0]           type_q, type_d;
  logic [CD_W-1:0]      cd_len_q, cd_len_d;
  logic [CD_W-1:0]      cd_cnt_q, cd_cnt_d;
  logic [3:0]           angle_q, angle_d;
  logic                 pulse_q, pulse_d;
  logic                 ready_q, ready_d;
  logic [1:0]           sniper_q, sniper_d;
  logic [15:0]          shots_q, shots_d;
  logic                 fire_ok;

  // Synchronizers and debouncers. The debounced level only moves after the
  // synchronized level has disagreed with it for DEBOUNCE_CYCLES cycles in a row;
  // any agreement in between restarts the count.
  always_comb begin
    sync1_d        = {key_fire, key_right, key_left};
    sync2_d        = sync1_q;
    pressed_prev_d = pressed_q;
    pressed_d      = pressed_q;
    db_cnt_d       = db_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (~sync2_q[i] != pressed_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          pressed_d[i] = ~sync2_q[i];
          db_cnt_d[i]  = '0;
        end else begin
          db_cnt_d[i]  = db_cnt_q[i] + 1'b1;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Release->press transition of the debounced level, one cycle wide.
  assign evt = pressed_q & ~pressed_prev_q;

  // A shot is possible with a weapon selected and, for the sniper, a charge left.
  assign fire_ok = (shootingtype != 2'b00) &&
                   !((shootingtype == 2'b11) && (sniper_q == 2'd0));

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    cd_len_d = cd_len_q;
    cd_cnt_d = cd_cnt_q;
    angle_d  = angle_q;
    sniper_d = sniper_q;
    shots_d  = shots_q;

    unique case (state_q)
      S_IDLE: begin
        if (evt[K_FIRE] && fire_ok) begin
          state_d = S_FIRE;
          type_d  = shootingtype;
        end
      end
      S_FIRE: begin
        state_d  = S_COOLDOWN;
        cd_cnt_d = '0;
        // Length comes from the weapon captured at acceptance, so SW changes
        // after the press cannot shorten or extend this cooldown.
        unique case (type_q)
          2'b10:   cd_len_d = CD_W'(COOLDOWN_DOUBLE);
          2'b11:   cd_len_d = CD_W'(COOLDOWN_SNIPER);
          default: cd_len_d = CD_W'(COOLDOWN_SPREAD);
        endcase
        shots_d = (shots_q == 16'hFFFF) ? shots_q : shots_q + 16'd1;
        if (type_q == 2'b11) begin
          sniper_d = sniper_q - 2'd1;
        end
      end
      S_COOLDOWN: begin
        if (cd_cnt_q == cd_len_q - 1'b1) begin
          cd_cnt_d = '0;
`ifdef AUTOFIRE_EN
          // Held key re-fires without a new press; sniper stops once empty
          // because fire_ok sees the already-decremented charge count.
          if (pressed_q[K_FIRE] && fire_ok) begin
            state_d = S_FIRE;
            type_d  = shootingtype;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end else begin
          cd_cnt_d = cd_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The angle is frozen during FIRE so every enemy samples one stable value.
    if (state_q != S_FIRE) begin
      unique case ({evt[K_LEFT], evt[K_RIGHT]})
        2'b10:   angle_d = angle_q - 4'd1;
        2'b01:   angle_d = angle_q + 4'd1;
        default: angle_d = angle_q;
      endcase
    end

    // Registered outputs track the state being entered.
    pulse_d = (state_d == S_FIRE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q        <= 3'b111;
      sync2_q        <= 3'b111;
      pressed_q      <= 3'b000;
      pressed_prev_q <= 3'b000;
      db_cnt_q       <= '0;
      state_q        <= S_IDLE;
      type_q         <= 2'b00;
      cd_len_q       <= CD_W'(COOLDOWN_SPREAD);
      cd_cnt_q       <= '0;
      angle_q        <= 4'd0;
      pulse_q        <= 1'b0;
      ready_q        <= 1'b0;
      sniper_q       <= 2'(SNIPER_CHARGES);
      shots_q        <= 16'd0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      pressed_q      <= pressed_d;
      pressed_prev_q <= pressed_prev_d;
      db_cnt_q       <= db_cnt_d;
      state_q        <= state_d;
      type_q         <= type_d;
      cd_len_q       <= cd_len_d;
      cd_cnt_q       <= cd_cnt_d;
      angle_q        <= angle_d;
      pulse_q        <= pulse_d;
      ready_q        <= ready_d;
      sniper_q       <= sniper_d;
      shots_q        <= shots_d;
    end
  end

  assign hit_angle            = angle_q;
  assign outgoing_projectiles = pulse_q;
  assign ready                = ready_q;
  assign sniper_left          = sniper_q;
  assign shots_fired          = shots_q;

endmodule

// File: tb/tb_shot_controller.sv
// Purpose : directed bench for shot_controller with short debounce/cooldown values.
// Latency : a fire drive after edge k is expected as a pulse sampled in cycle k+7.
// Backpr. : none; expected pulses are queued at drive time and popped on each pulse.
module tb_shot_controller;

  logic        clk;
  logic        reset_n;
  logic        key_left;
  logic        key_right;
  logic        key_fire;
  logic [1:0]  shootingtype;
  logic [3:0]  hit_angle;
  logic        outgoing_projectiles;
  logic        ready;
  logic [1:0]  sniper_left;
  logic [15:0] shots_fired;

  shot_controller #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_SPREAD(8),
    .COOLDOWN_DOUBLE(16),
    .COOLDOWN_SNIPER(32),
    .SNIPER_CHARGES (3)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .key_left            (key_left),
    .key_right           (key_right),
    .key_fire            (key_fire),
    .shootingtype        (shootingtype),
    .hit_angle           (hit_angle),
    .outgoing_projectiles(outgoing_projectiles),
    .ready               (ready),
    .sniper_left         (sniper_left),
    .shots_fired         (shots_fired)
  );

  typedef struct {
    logic [3:0] angle;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         cyc         = 0;
  logic [3:0] ang;
  int         k;
  int         n_shots;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_neg(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic rot(input bit l, input bit r);
    key_left  = l ? 1'b0 : 1'b1;
    key_right = r ? 1'b0 : 1'b1;
    step(8);
    key_left  = 1'b1;
    key_right = 1'b1;
    step(8);
  endtask

  // A press held 7 cycles is debounced as one press and released again
  // before the shortest cooldown ends.
  task automatic fire(input bit expect_pulse, input int gap);
    exp_t e;
    if (expect_pulse) begin
      e.angle = ang;
      e.cyc   = cyc + 7;
      exp_q.push_back(e);
    end
    key_fire = 1'b0;
    step(7);
    key_fire = 1'b1;
    step(gap);
  endtask

  // Scoreboard: every pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (outgoing_projectiles === 1'b1) begin
        chk("pulse_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pulse_angle", 32'(hit_angle), 32'(e.angle));
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    exp_t e;
    reset_n      = 1'b1;
    key_left     = 1'b1;
    key_right    = 1'b1;
    key_fire     = 1'b1;
    shootingtype = 2'b00;
    ang          = 4'd0;
    #2 reset_n = 1'b0;
    step(3);
    chk("rst_angle",  32'(hit_angle), 0);
    chk("rst_pulse",  32'(outgoing_projectiles), 0);
    chk("rst_ready",  32'(ready), 0);
    chk("rst_sniper", 32'(sniper_left), 3);
    chk("rst_shots",  32'(shots_fired), 0);
    reset_n = 1'b1;
    step(2);
    chk("idle_ready", 32'(ready), 1);

    // Rotation with wrap-around and simultaneous left/right.
    rot(0, 1);
    chk("right_once", 32'(hit_angle), 1);
    rot(1, 0);
    rot(1, 0);
    chk("left_wrap", 32'(hit_angle), 15);
    rot(1, 1);
    chk("left_right_same", 32'(hit_angle), 15);

    // No weapon selected: press is ignored.
    ang = 4'd15;
    fire(0, 20);
    chk("none_shots", 32'(shots_fired), 0);
    chk("none_ready", 32'(ready), 1);

    repeat (6) rot(0, 1);
    chk("angle_five", 32'(hit_angle), 5);
    ang = 4'd5;

    // Spread shot: pulse at k+7, ready back exactly 8 cycles after the pulse ends.
    shootingtype = 2'b01;
    k = cyc;
    e.angle = ang;
    e.cyc   = k + 7;
    exp_q.push_back(e);
    key_fire = 1'b0;
    step(7);
    key_fire = 1'b1;
    wait_neg(k + 15);
    chk("spread_ready_low", 32'(ready), 0);
    wait_neg(k + 16);
    chk("spread_ready_high", 32'(ready), 1);
    chk("spread_shots", 32'(shots_fired), 1);
    step(10);

    // Bouncing fire key: only the final stable low produces one pulse.
    repeat (5) begin
      key_fire = 1'b0;
      step(2);
      key_fire = 1'b1;
      step(2);
    end
    fire(1, 20);
    chk("bounce_shots", 32'(shots_fired), 2);
    chk("bounce_pending", exp_q.size(), 0);

    // Double shot: re-press lands in cooldown and is dropped; a mid-cooldown
    // weapon change does not alter the running cooldown length.
    shootingtype = 2'b10;
    k = cyc;
    e.angle = ang;
    e.cyc   = k + 7;
    exp_q.push_back(e);
    key_fire = 1'b0;
    step(6);
    key_fire = 1'b1;
    step(4);
    key_fire     = 1'b0;
    shootingtype = 2'b01;
    step(5);
    key_fire = 1'b1;
    wait_neg(k + 23);
    chk("double_ready_low", 32'(ready), 0);
    wait_neg(k + 24);
    chk("double_ready_high", 32'(ready), 1);
    step(10);
    chk("double_shots", 32'(shots_fired), 3);
    chk("double_pending", exp_q.size(), 0);

    // Sniper: three charges, fourth press ignored.
    shootingtype = 2'b11;
    for (int i = 0; i < 4; i++) begin
      fire(i < 3, 40);
      if (i == 0) chk("sniper_after_one", 32'(sniper_left), 2);
    end
    chk("sniper_empty", 32'(sniper_left), 0);
    chk("sniper_ready", 32'(ready), 1);
    chk("sniper_shots", 32'(shots_fired), 6);
    chk("sniper_pending", exp_q.size(), 0);

    // Reset 5 cycles into a double cooldown.
    shootingtype = 2'b10;
    k = cyc;
    e.angle = ang;
    e.cyc   = k + 7;
    exp_q.push_back(e);
    key_fire = 1'b0;
    step(7);
    key_fire = 1'b1;
    step_to(k + 13);
    reset_n = 1'b0;
    #1;
    chk("midrst_angle",  32'(hit_angle), 0);
    chk("midrst_pulse",  32'(outgoing_projectiles), 0);
    chk("midrst_ready",  32'(ready), 0);
    chk("midrst_sniper", 32'(sniper_left), 3);
    chk("midrst_shots",  32'(shots_fired), 0);
    step(3);
    reset_n = 1'b1;
    step(2);
    ang = 4'd0;
    fire(1, 40);
    chk("post_rst_shots", 32'(shots_fired), 1);
    chk("post_rst_pending", exp_q.size(), 0);

    // Held fire key for 40 cycles.
    shootingtype = 2'b01;
    k = cyc;
`ifdef AUTOFIRE_EN
    n_shots = 5;
`else
    n_shots = 1;
`endif
    for (int i = 0; i < n_shots; i++) begin
      e.angle = ang;
      e.cyc   = k + 7 + 9 * i;
      exp_q.push_back(e);
    end
    key_fire = 1'b0;
    step(40);
    key_fire = 1'b1;
    step(30);
    chk("hold_shots", 32'(shots_fired), 32'(1 + n_shots));
    chk("final_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
